// File: rtl/shannon_whitaker_coeff_ctrl.sv
// shannon_whitaker_coeff_ctrl
//   Run-time coefficient controller for the 8-sample-per-clock
//   Shannon-Whittaker lowpass. It keeps a shadow bank that the config
//   side writes and an active bank that drives the DSP core. A commit
//   swaps the banks in one cycle. The filter is then held in reset while
//   its pipeline flushes, and its output stays unqualified until the
//   pipeline holds only samples produced with the new coefficients.
//
// Optional feature: define SW_LPF_READBACK_EN to add a registered
//   readback port for the shadow bank (rb_addr_i / rb_data_o).
//
// Ports
//   clk_i        filter clock
//   rst_ni       asynchronous active-low reset
//   cfg_wr_i     shadow write strobe (taken in RUN only)
//   cfg_addr_i   shadow index, 0=B1 ... 7=B15
//   cfg_data_i   signed coefficient, before the upshift
//   cfg_commit_i request a shadow->active swap
//   cfg_busy_o   high while swapping or flushing
//   cfg_err_o    sticky error flag, cleared by an accepted commit
//   coeff_o      active bank << COEFF_UPSHIFT, index k at [k*CWIDTH +: CWIDTH]
//   filt_rst_o   synchronous reset to the filter core
//   dat_valid_o  filter output qualifier
//   rb_addr_i    (readback build) shadow index to read
//   rb_data_o    (readback build) registered shadow[rb_addr_i]
module shannon_whitaker_coeff_ctrl #(
  parameter int NCOEFF        = 8,
  parameter int CWIDTH        = 18,
  parameter int COEFF_UPSHIFT = 3,
  parameter int FLUSH_CYCLES  = 14
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_wr_i,
  input  logic [$clog2(NCOEFF)-1:0]     cfg_addr_i,
  input  logic [CWIDTH-1:0]             cfg_data_i,
  input  logic                          cfg_commit_i,
  output logic                          cfg_busy_o,
  output logic                          cfg_err_o,
  output logic [NCOEFF*CWIDTH-1:0]      coeff_o,
  output logic                          filt_rst_o,
`ifdef SW_LPF_READBACK_EN
  input  logic [$clog2(NCOEFF)-1:0]     rb_addr_i,
  output logic [CWIDTH-1:0]             rb_data_o,
`endif
  output logic                          dat_valid_o
);

  localparam int AW = $clog2(NCOEFF);
  localparam int CW = $clog2(2 * FLUSH_CYCLES);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] SWAP  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [CW-1:0] CNT_LAST  = CW'(2 * FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_RSTND = CW'(FLUSH_CYCLES);

  // Power-on coefficients B1..B15 of the reference lowpass.
  function automatic logic [CWIDTH-1:0] dflt(input int k);
    case (k)
      0:       return CWIDTH'(-23);
      1:       return CWIDTH'(105);
      2:       return CWIDTH'(-263);
      3:       return CWIDTH'(526);
      4:       return CWIDTH'(-949);
      5:       return CWIDTH'(1672);
      6:       return CWIDTH'(-3216);
      default: return CWIDTH'(10342);
    endcase
  endfunction

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic          err_reg;
  logic          in_range;
  logic          wr_ok;
  logic          running;

  logic [CWIDTH-1:0] shadow    [NCOEFF];
  logic [CWIDTH-1:0] active    [NCOEFF];
  logic [CWIDTH-1:0] coeff_reg [NCOEFF];

  // The value must survive the upshift unchanged: the sign bit plus the
  // COEFF_UPSHIFT bits above the kept field must all agree.
  logic [COEFF_UPSHIFT:0] top_bits;
  assign top_bits = cfg_data_i[CWIDTH-1 -: COEFF_UPSHIFT+1];
  assign in_range = (&top_bits) | ~(|top_bits);

  assign running = (state_reg == RUN);
  assign wr_ok   = running & cfg_wr_i & in_range;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (cfg_commit_i) state_next = SWAP;
      SWAP:    state_next = FLUSH;
      FLUSH:   if (cnt_reg == CNT_LAST) state_next = RUN;
      default: state_next = FLUSH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= FLUSH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == FLUSH && cnt_reg != CNT_LAST) cnt_reg <= cnt_reg + 1'b1;
      else                                           cnt_reg <= '0;
    end
  end

  // Any request while busy is an error, even in the swap cycle that would
  // otherwise clear the flag for the commit that caused it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_reg <= 1'b0;
    end else if (!running && (cfg_wr_i || cfg_commit_i)) begin
      err_reg <= 1'b1;
    end else if (running && cfg_wr_i && !in_range) begin
      err_reg <= 1'b1;
    end else if (state_reg == SWAP) begin
      err_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCOEFF; gi++) begin : g_bank
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          shadow[gi]    <= dflt(gi);
          active[gi]    <= dflt(gi);
          coeff_reg[gi] <= dflt(gi) << COEFF_UPSHIFT;
        end else begin
          if (wr_ok && cfg_addr_i == AW'(gi)) shadow[gi] <= cfg_data_i;
          if (state_reg == SWAP)              active[gi] <= shadow[gi];
          // Follows active one edge later; active only moves in SWAP.
          coeff_reg[gi] <= active[gi] << COEFF_UPSHIFT;
        end
      end
      assign coeff_o[gi*CWIDTH +: CWIDTH] = coeff_reg[gi];
    end
  endgenerate

`ifdef SW_LPF_READBACK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rb_data_o <= '0;
    else         rb_data_o <= shadow[rb_addr_i];
  end
`endif

  assign cfg_busy_o  = !running;
  assign cfg_err_o   = err_reg;
  assign dat_valid_o = running;
  assign filt_rst_o  = (state_reg == SWAP) ||
                       (state_reg == FLUSH && cnt_reg < CNT_RSTND);

endmodule

// File: tb/tb_shannon_whitaker_coeff_ctrl.sv
module tb_shannon_whitaker_coeff_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_wr = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [17:0]  cfg_data = '0;
  logic         cfg_commit = 1'b0;
  logic         cfg_busy;
  logic         cfg_err;
  logic [143:0] coeff;
  logic         filt_rst;
  logic         dat_valid;
`ifdef SW_LPF_READBACK_EN
  logic [2:0]   rb_addr = '0;
  logic [17:0]  rb_data;
`endif

  always #5 clk = ~clk;

  shannon_whitaker_coeff_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_wr_i     (cfg_wr),
    .cfg_addr_i   (cfg_addr),
    .cfg_data_i   (cfg_data),
    .cfg_commit_i (cfg_commit),
    .cfg_busy_o   (cfg_busy),
    .cfg_err_o    (cfg_err),
    .coeff_o      (coeff),
    .filt_rst_o   (filt_rst),
`ifdef SW_LPF_READBACK_EN
    .rb_addr_i    (rb_addr),
    .rb_data_o    (rb_data),
`endif
    .dat_valid_o  (dat_valid)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: coefficient banks as plain integers, and the
  // post-commit sequence as "cycles left until valid" / "cycles left in reset".
  int defs [8] = '{-23, 105, -263, 526, -949, 1672, -3216, 10342};
  int sh   [8];
  int snap [8];
  int expc [8];
  int busy_left;
  int rst_left;
  int coeff_delay;
  bit err_m;
  bit in_swap;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic spot(input string tag, input int k, input int v);
    logic [143:0] g;
    logic [143:0] e;
    g = '0;
    e = '0;
    g[17:0] = coeff[k*18 +: 18];
    e[17:0] = v[17:0];
    chk(tag, g, e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      sh[k]   = defs[k];
      expc[k] = defs[k];
      snap[k] = defs[k];
    end
    busy_left   = 28;
    rst_left    = 14;
    coeff_delay = 0;
    err_m       = 1'b0;
    in_swap     = 1'b0;
  endtask

  task automatic model_edge(input bit wr, input int a, input logic [17:0] d, input bit cm);
    int  dv;
    bit  was_swap;
    dv       = int'($signed(d));
    was_swap = in_swap;
    in_swap  = 1'b0;
    if (coeff_delay > 0) begin
      coeff_delay--;
      if (coeff_delay == 0) expc = snap;
    end
    if (busy_left == 0) begin
      if (wr) begin
        if (dv >= -16384 && dv < 16384) sh[a] = dv;
        else                            err_m = 1'b1;
      end
      if (cm) begin
        snap        = sh;
        busy_left   = 29;
        rst_left    = 15;
        in_swap     = 1'b1;
        coeff_delay = 2;
      end
    end else begin
      if (wr || cm)      err_m = 1'b1;
      else if (was_swap) err_m = 1'b0;
      busy_left--;
      if (rst_left > 0) rst_left--;
    end
  endtask

  task automatic check_all();
    logic [143:0] e;
    int t;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      t = expc[k] * 8;
      e[k*18 +: 18] = t[17:0];
    end
    chk("coeff", coeff, e);
    chk("filt_rst", 144'(filt_rst), 144'(rst_left > 0));
    chk("dat_valid", 144'(dat_valid), 144'(busy_left == 0));
    chk("busy", 144'(cfg_busy), 144'(busy_left > 0));
    chk("err", 144'(cfg_err), 144'(err_m));
  endtask

  // One clock: drive, check pre-edge outputs, clock the model with the DUT.
  task automatic cyc(input bit wr, input int a, input int d, input bit cm);
    cfg_wr     = wr;
    cfg_addr   = a[2:0];
    cfg_data   = d[17:0];
    cfg_commit = cm;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst_n) model_edge(wr, a, d[17:0], cm);
    #1;
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int v;
    model_reset();
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // 1: post-reset flush and default bank
    idle(30);
    spot("b7_default", 7, 82736);
    spot("b0_default", 0, -184);

    // 2: write B15, commit
    cyc(1'b1, 7, 8000, 1'b0);
    cyc(1'b0, 0, 0, 1'b1);
    idle(31);
    spot("b15_commit", 7, 64000);

    // 3: out-of-range write, then commit clears error
    cyc(1'b1, 3, 20000, 1'b0);
    cyc(1'b0, 0, 0, 1'b1);
    idle(31);
    spot("b7_keep", 3, 4208);

    // 4: write and second commit during flush are ignored
    cyc(1'b1, 1, 999, 1'b0);
    cyc(1'b0, 0, 0, 1'b1);
    idle(4);
    cyc(1'b1, 0, 77, 1'b1);
    idle(30);

    // 5: write and commit in the same cycle
    cyc(1'b1, 2, -500, 1'b1);
    idle(31);
    spot("b5_same_cycle", 2, -4000);

    // 6: reset during flush restarts from defaults
    cyc(1'b0, 0, 0, 1'b1);
    idle(7);
    rst_n = 1'b0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(30);
    spot("b7_after_rst", 7, 82736);

`ifdef SW_LPF_READBACK_EN
    // 7: readback of a shadow write before any commit
    cyc(1'b1, 5, 1234, 1'b0);
    rb_addr = 3'd5;
    idle(1);
    @(negedge clk);
    chk("readback", 144'(rb_data), 144'(1234));
`endif

    // Randomized traffic, including requests while busy
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) v = int'($urandom_range(0, 200000)) - 100000;
      else                           v = int'($urandom_range(0, 32767)) - 16384;
      cyc($urandom_range(0, 9) < 3, int'($urandom_range(0, 7)), v,
          $urandom_range(0, 19) == 0);
    end
    idle(32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
